// File: rtl/opl_timer_bank.sv
// Bank of independent up-counting interval timers with per-channel prescale,
// sticky overflow flags and a shared IRQ built from those flags.
module opl_timer_bank #(
    parameter int unsigned                  NUM_TIMERS = 2,
    parameter int unsigned                  WIDTH      = 8,
    parameter logic [NUM_TIMERS*16-1:0]     PRESCALE   = {16'd1144, 16'd286}
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clk_en,
    input  logic [NUM_TIMERS*WIDTH-1:0]     init,
    input  logic [NUM_TIMERS-1:0]           start,
    input  logic [NUM_TIMERS-1:0]           mask,
    input  logic                            irq_reset,
    output logic [NUM_TIMERS-1:0]           overflow,
    output logic [NUM_TIMERS-1:0]           flag,
    output logic                            irq
);

    logic [NUM_TIMERS-1:0] start_q;
    logic [WIDTH-1:0]      counter_q [NUM_TIMERS];
    logic [WIDTH-1:0]      counter_d [NUM_TIMERS];
    logic [15:0]           presc_q   [NUM_TIMERS];
    logic [15:0]           presc_d   [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] ovf_q, ovf_d;
    logic [NUM_TIMERS-1:0] flag_q, flag_d;

    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            counter_d[i] = counter_q[i];
            presc_d[i]   = presc_q[i];
            ovf_d[i]     = 1'b0;
            // A rising start always reloads, so a stopped timer restarts rather than resumes.
            if (start[i] && !start_q[i]) begin
                counter_d[i] = init[i*WIDTH +: WIDTH];
                presc_d[i]   = PRESCALE[i*16 +: 16] - 16'd1;
            end else if (start[i] && clk_en) begin
                if (presc_q[i] == 16'd0) begin
                    presc_d[i] = PRESCALE[i*16 +: 16] - 16'd1;
                    if (counter_q[i] == {WIDTH{1'b1}}) begin
                        counter_d[i] = init[i*WIDTH +: WIDTH];
                        ovf_d[i]     = 1'b1;
                    end else begin
                        counter_d[i] = counter_q[i] + 1'b1;
                    end
                end else begin
                    presc_d[i] = presc_q[i] - 16'd1;
                end
            end
            // Setting by an unmasked overflow wins over a simultaneous clear.
            flag_d[i] = (ovf_d[i] & ~mask[i]) | (flag_q[i] & ~irq_reset);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= '0;
            ovf_q   <= '0;
            flag_q  <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                counter_q[i] <= '0;
                presc_q[i]   <= PRESCALE[i*16 +: 16] - 16'd1;
            end
        end else begin
            start_q <= start;
            ovf_q   <= ovf_d;
            flag_q  <= flag_d;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                counter_q[i] <= counter_d[i];
                presc_q[i]   <= presc_d[i];
            end
        end
    end

    assign overflow = ovf_q;
    assign flag     = flag_q;
    assign irq      = |flag_q;

endmodule

// File: tb/tb_opl_timer_bank.sv
// Directed bench for opl_timer_bank: channel 0 prescale 2, channel 1 prescale 4.
module tb_opl_timer_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic [15:0] init;
    logic [1:0]  start;
    logic [1:0]  mask;
    logic        irq_reset;
    logic [1:0]  overflow;
    logic [1:0]  flag;
    logic        irq;

    int total = 0;
    int bad   = 0;
    logic toggle_en = 1'b0;

    opl_timer_bank #(
        .NUM_TIMERS (2),
        .WIDTH      (8),
        .PRESCALE   ({16'd4, 16'd2})
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .init      (init),
        .start     (start),
        .mask      (mask),
        .irq_reset (irq_reset),
        .overflow  (overflow),
        .flag      (flag),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Advance n edges; sample and drive 1 time unit after each edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (toggle_en) clk_en = ~clk_en;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        clk_en    = 1'b1;
        init      = 16'h0000;
        start     = 2'b00;
        mask      = 2'b00;
        irq_reset = 1'b0;
        #2;
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_flag", 32'(flag), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // Ch0 init FE: overflow every 4 cycles
        init[7:0] = 8'hFE;
        start[0]  = 1'b1;
        tick(1);
        tick(3);
        chk("t1_ovf_early", 32'(overflow[0]), 32'h0);
        tick(1);
        chk("t1_ovf_first", 32'(overflow[0]), 32'h1);
        chk("t1_flag_first", 32'(flag[0]), 32'h1);
        chk("t1_irq_first", 32'(irq), 32'h1);
        tick(1);
        chk("t1_ovf_pulse_end", 32'(overflow[0]), 32'h0);
        chk("t1_flag_sticky", 32'(flag[0]), 32'h1);
        tick(3);
        chk("t1_ovf_second", 32'(overflow[0]), 32'h1);
        start[0]  = 1'b0;
        irq_reset = 1'b1;
        tick(1);
        chk("t1_clear_flag", 32'(flag), 32'h0);
        chk("t1_clear_irq", 32'(irq), 32'h0);
        irq_reset = 1'b0;

        // Ch1 masked: pulses but no flag, then unmasked
        init[15:8] = 8'hFF;
        mask[1]    = 1'b1;
        start[1]   = 1'b1;
        tick(1);
        tick(3);
        chk("t2_ovf_early", 32'(overflow[1]), 32'h0);
        tick(1);
        chk("t2_ovf_a", 32'(overflow[1]), 32'h1);
        chk("t2_flag_a", 32'(flag[1]), 32'h0);
        chk("t2_irq_a", 32'(irq), 32'h0);
        tick(4);
        chk("t2_ovf_b", 32'(overflow[1]), 32'h1);
        chk("t2_flag_b", 32'(flag[1]), 32'h0);
        chk("t2_irq_b", 32'(irq), 32'h0);
        mask[1] = 1'b0;
        tick(4);
        chk("t2_ovf_unmasked", 32'(overflow[1]), 32'h1);
        chk("t2_flag_unmasked", 32'(flag[1]), 32'h1);
        chk("t2_irq_unmasked", 32'(irq), 32'h1);

        // irq_reset colliding with a ch0 overflow
        start[0] = 1'b1;
        tick(1);
        tick(3);
        chk("t3_ovf1", 32'(overflow[1]), 32'h1);
        irq_reset = 1'b1;
        tick(1);
        chk("t3_ovf0", 32'(overflow[0]), 32'h1);
        chk("t3_flag_set_wins", 32'(flag), 32'h1);
        chk("t3_irq", 32'(irq), 32'h1);
        tick(1);
        chk("t3_flag_cleared", 32'(flag), 32'h0);
        chk("t3_irq_cleared", 32'(irq), 32'h0);
        irq_reset = 1'b0;
        start     = 2'b00;
        tick(1);

        // Ch0 init FC with clk_en toggling, then stop/restart
        init[7:0] = 8'hFC;
        start[0]  = 1'b1;
        toggle_en = 1'b1;
        tick(1);
        tick(15);
        chk("t4_ovf_early", 32'(overflow[0]), 32'h0);
        tick(1);
        chk("t4_ovf_16clk", 32'(overflow[0]), 32'h1);
        tick(4);
        start[0] = 1'b0;
        tick(10);
        chk("t4_stopped", 32'(overflow[0]), 32'h0);
        start[0] = 1'b1;
        tick(1);
        tick(1);
        chk("t4_no_resume", 32'(overflow[0]), 32'h0);
        tick(13);
        chk("t4_restart_early", 32'(overflow[0]), 32'h0);
        tick(1);
        chk("t4_restart_ovf", 32'(overflow[0]), 32'h1);
        toggle_en = 1'b0;
        clk_en    = 1'b1;

        // init change mid-period only affects the next reload
        start[0]  = 1'b0;
        init[7:0] = 8'hFE;
        tick(1);
        start[0] = 1'b1;
        tick(1);
        tick(1);
        init[7:0] = 8'hFC;
        tick(2);
        chk("t5_ovf_early", 32'(overflow[0]), 32'h0);
        tick(1);
        chk("t5_ovf_current", 32'(overflow[0]), 32'h1);
        tick(4);
        chk("t5_old_period", 32'(overflow[0]), 32'h0);
        tick(3);
        chk("t5_new_early", 32'(overflow[0]), 32'h0);
        tick(1);
        chk("t5_new_period", 32'(overflow[0]), 32'h1);
        chk("t5_flag", 32'(flag[0]), 32'h1);

        // Async reset mid-run with start held high
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ovf", 32'(overflow), 32'h0);
        chk("t6_rst_flag", 32'(flag), 32'h0);
        chk("t6_rst_irq", 32'(irq), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        tick(7);
        chk("t6_ovf_early", 32'(overflow[0]), 32'h0);
        tick(1);
        chk("t6_ovf_after_rst", 32'(overflow[0]), 32'h1);
        chk("t6_flag_after_rst", 32'(flag[0]), 32'h1);
        chk("t6_irq_after_rst", 32'(irq), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opl_timer_bank.md
# opl_timer_bank

Parametrised bank of independent up-counting interval timers with per-channel prescale, start, mask and status flags, plus a shared IRQ output. Sits next to the OPL register file: the timer-load and timer-control registers drive `init`, `start`, `mask` and `irq_reset`; `flag` and `irq` feed the status register read path. Each channel's `overflow` pulse is also exported for CSM-style consumers. It replaces per-timer instances with one block that owns the flag/IRQ logic.

## Interface
- `NUM_TIMERS`, 2, number of timer channels (≥1)
- `WIDTH`, 8, counter width per channel
- `PRESCALE`, {16'd1144, 16'd286}, packed NUM_TIMERS×16 vector; slice i = enabled clocks per count of channel i (≥1)
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `clk_en`  in  1  tick enable; prescalers advance only when high
- `init`  in  NUM_TIMERS×WIDTH  reload value per channel, slice i = bits [i*WIDTH +: WIDTH]
- `start`  in  NUM_TIMERS  run level per channel
- `mask`  in  NUM_TIMERS  1 = channel does not set its flag
- `irq_reset`  in  1  single-cycle pulse, clears all flags
- `overflow`  out  NUM_TIMERS  one-cycle overflow pulse per channel
- `flag`  out  NUM_TIMERS  sticky overflow flag per channel
- `irq`  out  1  OR of all flags

## Operation
- Per channel: registers `start_d`, `counter[WIDTH]`, `prescaler[16]`.
- Load: `start & ~start_d` → `counter<=init`, `prescaler<=PRESCALE_i-1`. Happens regardless of `clk_en`. Has priority over counting.
- Count: `start & start_d & clk_en` → `prescaler` decrements; when `prescaler==0`, it reloads to `PRESCALE_i-1` and `counter` increments.
- Overflow: an increment with `counter` all-ones → `counter<=init`, `overflow_i<=1` for one cycle. No wrap through zero.
- Stop: `start=0` → `counter` and `prescaler` hold. Re-raising `start` reloads both, so counting restarts; it does not resume.
- `init` is sampled only at load/overflow reload. Changing `init` mid-run has no effect until the next reload.
- Flags:
  - On an `overflow_i` event with `mask_i=0`, `flag_i` sets.
  - When `mask_i=1`, the timer still runs and pulses `overflow_i`, but `flag_i` is not set. Raising `mask` does not clear an existing flag.
- `irq_reset` clears all flags. If an overflow sets a flag in the same cycle, set wins for that channel; the other channels still clear.
- `irq = |flag`, combinational from registered flags.
- Channels are fully independent; simultaneous overflows on several channels are all reported.

## Timing
- Reset (async assert) values:
  - `overflow=0`, `flag=0`, `irq=0`
  - `counter=0`, `prescaler=PRESCALE_i-1`, `start_d=0`
- If `start` is held high through reset release, the first clock edge after release is a load.
- Period:
  - After the load edge, the first overflow edge follows after (2^WIDTH − init)×PRESCALE_i enabled cycles.
  - `overflow_i` is high for exactly one cycle after that edge.
  - `flag_i` is visible in the same cycle as the `overflow_i` pulse; `irq` is visible in that cycle too.
- Steady period = (2^WIDTH − init)×PRESCALE_i enabled cycles.
- init = all-ones gives the minimum period, PRESCALE_i.
- PRESCALE_i = 1 gives one count per enabled cycle.
- `clk_en` low: no state change except load and flag clear.
- `irq_reset` takes effect at the next edge; `flag`/`irq` are low the following cycle unless an overflow set them in that cycle.
- No combinational path from inputs to `overflow`/`flag`. `irq` depends only on registers.

## Test plan
Bench parameters: WIDTH=8, NUM_TIMERS=2, PRESCALE={16'd4,16'd2}.

1. `clk_en=1`; ch0 `init=8'hFE`; raise `start[0]` → first `overflow[0]` 4 cycles after the load edge. `flag[0]=1` and `irq=1` in the same cycle. `overflow[0]` repeats every 4 cycles; flag stays set.
2. ch1 `init=8'hFF`, `mask[1]=1`, `start[1]` high → `overflow[1]` pulses every 4 cycles; `flag[1]=0` and `irq=0` throughout. Then `mask[1]=0` → the next overflow sets `flag[1]`.
3. `irq_reset` on the same edge as a ch0 overflow, with `flag[1]` already set → `flag[0]=1`, `flag[1]=0`, `irq=1`. A lone `irq_reset` one cycle later → all flags 0, `irq=0`.
4. ch0 `init=8'hFC`, `clk_en` toggling 1/0 → overflow every 16 clocks. Drop `start[0]` mid-count for 10 cycles, then raise it → next overflow comes a full 8 enabled cycles after the re-raise.
5. Change ch0 `init` from 8'hFE to 8'hFC mid-period → the current period is unaffected; the following period is 8 enabled cycles.
6. Assert `reset_n=0` mid-count with `start` held high → `overflow`, `flag`, `irq` go 0 immediately. After release, first overflow comes (256−init)×PRESCALE enabled cycles after the first edge.
